// File: rtl/gate_exerciser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gate_exerciser_pkg
//  Description : Shared types and constants for the gate exerciser. Holds the
//                controller state encoding and the number of input vectors
//                applied to a 2-input gate in one run.
//  Revision    : 1.0 - initial release
// ============================================================================
package gate_exerciser_pkg;

    // One vector per row of a 2-input truth table.
    localparam int unsigned c_VEC_COUNT = 4;
    localparam logic [1:0]  c_LAST_VEC  = 2'(c_VEC_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : gate_exerciser_pkg
`default_nettype wire

// File: rtl/gate_exerciser_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Single-bit two-flop synchronizer, synchronous active-low
//                reset to 0.
//  Ports       : clk   - clock
//                rst_n - synchronous active-low reset
//                i_d   - asynchronous input bit
//                o_q   - synchronized output (two cycles of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/gate_exerciser.sv
`default_nettype none
// ============================================================================
//  Module      : gate_exerciser
//  Description : Applies the four input vectors {gate_a,gate_b} = 0..3 to a
//                2-input gate, samples the gate response after a settle
//                period and compares it with an expected truth table.
//                Optional macro GATE_EXERCISER_SYNC_EN inserts a two-flop
//                synchronizer on gate_y and stretches every vector period
//                by two cycles to cover its latency.
//  Parameters  : SETTLE_CYC - settle cycles per vector (1..15)
//                EXPECT     - expected truth table, bit k for vector k
//  Ports       : clk      - clock, rising edge
//                rst_n    - synchronous active-low reset
//                start    - request a run (accepted only in IDLE)
//                gate_y   - response of the gate under test
//                gate_a   - stimulus MSB (registered)
//                gate_b   - stimulus LSB (registered)
//                busy     - run in progress
//                done     - one-cycle completion pulse
//                pass     - last run had no mismatches
//                fail_vec - per-vector mismatch flags of the last run
//                err_cnt  - mismatch count of the last run
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [3:0]  EXPECT     = 4'b1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   gate_y,
    output logic                   gate_a,
    output logic                   gate_b,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [c_VEC_COUNT-1:0] fail_vec,
    output logic [2:0]             err_cnt
);

    logic w_y;

`ifdef GATE_EXERCISER_SYNC_EN
    // Two extra settle cycles let the response propagate through the
    // synchronizer before it is compared.
    localparam logic [4:0] c_SETTLE_LEN = 5'(SETTLE_CYC + 2);

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (gate_y),
        .o_q   (w_y)
    );
`else
    localparam logic [4:0] c_SETTLE_LEN = 5'(SETTLE_CYC);

    assign w_y = gate_y;
`endif

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [4:0]               r_cnt,      w_cnt_nxt;
    logic [1:0]               r_idx,      w_idx_nxt;
    logic                     r_gate_a,   w_gate_a_nxt;
    logic                     r_gate_b,   w_gate_b_nxt;
    logic                     r_busy,     w_busy_nxt;
    logic                     r_done,     w_done_nxt;
    logic                     r_pass,     w_pass_nxt;
    logic [c_VEC_COUNT-1:0]   r_fail_vec, w_fail_vec_nxt;
    logic [2:0]               r_err_cnt,  w_err_cnt_nxt;
    logic                     w_mis;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. SETTLE lasts c_SETTLE_LEN cycles, SAMPLE one, so
    // each vector period is c_SETTLE_LEN + 1 cycles.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (r_cnt == c_SETTLE_LEN - 5'd1) w_state_nxt = ST_SAMPLE;
            ST_SAMPLE: w_state_nxt = (r_idx == c_LAST_VEC) ? ST_DONE : ST_SETTLE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next-value logic
    // ------------------------------------------------------------------
    assign w_mis = w_y ^ EXPECT[r_idx];

    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_gate_a_nxt   = r_gate_a;
        w_gate_b_nxt   = r_gate_b;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_pass_nxt     = r_pass;
        w_fail_vec_nxt = r_fail_vec;
        w_err_cnt_nxt  = r_err_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_cnt_nxt      = 5'd0;
                    w_idx_nxt      = 2'd0;
                    w_gate_a_nxt   = 1'b0;
                    w_gate_b_nxt   = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_pass_nxt     = 1'b0;
                    w_fail_vec_nxt = '0;
                    w_err_cnt_nxt  = 3'd0;
                end
            end
            ST_SETTLE: begin
                w_cnt_nxt = r_cnt + 5'd1;
            end
            ST_SAMPLE: begin
                w_cnt_nxt      = 5'd0;
                w_fail_vec_nxt = r_fail_vec | ({3'b000, w_mis} << r_idx);
                w_err_cnt_nxt  = r_err_cnt + {2'b00, w_mis};
                // The next vector goes out on the same edge as the sample;
                // the last vector stays on the pins through DONE.
                if (r_idx != c_LAST_VEC) begin
                    w_idx_nxt                    = r_idx + 2'd1;
                    {w_gate_a_nxt, w_gate_b_nxt} = r_idx + 2'd1;
                end
            end
            ST_DONE: begin
                w_busy_nxt   = 1'b0;
                w_done_nxt   = 1'b1;
                w_pass_nxt   = (r_err_cnt == 3'd0);
                w_gate_a_nxt = 1'b0;
                w_gate_b_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= 5'd0;
            r_idx      <= 2'd0;
            r_gate_a   <= 1'b0;
            r_gate_b   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_vec <= '0;
            r_err_cnt  <= 3'd0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_gate_a   <= w_gate_a_nxt;
            r_gate_b   <= w_gate_b_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_fail_vec <= w_fail_vec_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    assign gate_a   = r_gate_a;
    assign gate_b   = r_gate_b;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign fail_vec = r_fail_vec;
    assign err_cnt  = r_err_cnt;

endmodule : gate_exerciser
`default_nettype wire
